// File: rtl/lap_timer_if.sv
// Bundle of the lap_timer control inputs and display/status outputs.
// The master modport drives the controls; the timer core takes the slave side.
interface lap_timer_if #(
    parameter int DIGITS    = 4,
    parameter int LAP_DEPTH = 4
);
    logic                               init_regs;
    logic                               count_enabled;
    logic                               count_down;
    logic                               load;
    logic [4*DIGITS-1:0]                load_value;
    logic                               lap_push;
    logic                               lap_pop;
    logic                               show_lap;
    logic [4*DIGITS-1:0]                time_reading;
    logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count;
    logic                               lap_empty;
    logic                               lap_full;
    logic                               expired;
    logic                               overflow;

    modport master (
        output init_regs, count_enabled, count_down, load, load_value,
        output lap_push, lap_pop, show_lap,
        input  time_reading, lap_count, lap_empty, lap_full, expired, overflow
    );

    modport slave (
        input  init_regs, count_enabled, count_down, load, load_value,
        input  lap_push, lap_pop, show_lap,
        output time_reading, lap_count, lap_empty, lap_full, expired, overflow
    );
endinterface

// File: rtl/lap_timer.sv
// BCD stopwatch with prescaled tick and a small FIFO of captured lap readings.
// Define LAP_TIMER_COUNTDOWN_EN to enable count-down mode, preset load and the expired pulse.
module lap_timer #(
    parameter int CLK_FREQ  = 100000000,
    parameter int TICK_HZ   = 100,
    parameter int DIGITS    = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    lap_timer_if.slave bus
);
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [PRE_W-1:0] pre_reg, pre_next;
    logic [W-1:0]     digits_reg, digits_next;
    logic             overflow_reg, overflow_next;
    logic             expired_reg, expired_next;
    logic [W-1:0]     inc_value, dec_value, load_clamped;
    logic [DIGITS:0]  carry, borrow;
    logic             tick;
    logic             load_en, down_en;

    logic [W-1:0]     lap_mem [LAP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             lap_empty, lap_full, do_push, do_pop;

`ifdef LAP_TIMER_COUNTDOWN_EN
    assign load_en = bus.load;
    assign down_en = bus.count_down;
    assign bus.expired = expired_reg;
`else
    logic unused_cfg;
    assign load_en     = 1'b0;
    assign down_en     = 1'b0;
    assign bus.expired = 1'b0;
    assign unused_cfg  = &{1'b0, bus.load, bus.count_down, expired_reg};
`endif

    // Ripple carry/borrow chains: digit gi changes only if every lower digit wraps.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [3:0] lv;
            assign d  = digits_reg[4*gi +: 4];
            assign lv = bus.load_value[4*gi +: 4];
            assign carry[gi+1]  = carry[gi] & (d == 4'd9);
            assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
            assign inc_value[4*gi +: 4] = !carry[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign dec_value[4*gi +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign load_clamped[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;
        end
    endgenerate

    assign tick = bus.count_enabled && (pre_reg == PRE_W'(DIV - 1));

    always_comb begin
        pre_next      = pre_reg;
        digits_next   = digits_reg;
        overflow_next = overflow_reg;
        expired_next  = 1'b0;
        if (bus.init_regs) begin
            pre_next      = '0;
            digits_next   = '0;
            overflow_next = 1'b0;
        end else if (load_en) begin
            pre_next      = '0;
            digits_next   = load_clamped;
            overflow_next = 1'b0;
        end else if (bus.count_enabled) begin
            pre_next = tick ? '0 : pre_reg + PRE_W'(1);
            if (tick) begin
                if (down_en) begin
                    // Sitting at zero in count-down mode is terminal: no change, no pulse.
                    if (!borrow[DIGITS]) begin
                        digits_next  = dec_value;
                        expired_next = (dec_value == '0);
                    end
                end else begin
                    digits_next = inc_value;
                    if (carry[DIGITS]) overflow_next = 1'b1;
                end
            end
        end
    end

    assign lap_empty = (count_reg == '0);
    assign lap_full  = (count_reg == CNT_W'(LAP_DEPTH));
    assign do_pop    = bus.lap_pop && !lap_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push   = bus.lap_push && (!lap_full || do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LAP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_reg      <= '0;
            digits_reg   <= '0;
            overflow_reg <= 1'b0;
            expired_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            pre_reg      <= pre_next;
            digits_reg   <= digits_next;
            overflow_reg <= overflow_next;
            expired_reg  <= expired_next;
            if (bus.init_regs) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
                else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !bus.init_regs) lap_mem[wr_ptr_reg] <= digits_reg;
    end

    assign bus.time_reading = (bus.show_lap && !lap_empty) ? lap_mem[rd_ptr_reg] : digits_reg;
    assign bus.lap_count    = count_reg;
    assign bus.lap_empty    = lap_empty;
    assign bus.lap_full     = lap_full;
    assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer at 10 clocks per tick, 4 digits, 4 lap entries.
// Count-down scenarios run only when LAP_TIMER_COUNTDOWN_EN is defined.
module tb_lap_timer;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    lap_timer_if #(.DIGITS(4), .LAP_DEPTH(4)) bus ();

    lap_timer #(
        .CLK_FREQ (1000),
        .TICK_HZ  (100),
        .DIGITS   (4),
        .LAP_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_lap();
        bus.lap_push = 1'b1;
        step(1);
        bus.lap_push = 1'b0;
    endtask

    task automatic pop_lap();
        bus.lap_pop = 1'b1;
        step(1);
        bus.lap_pop = 1'b0;
    endtask

    task automatic pulse_init();
        bus.init_regs = 1'b1;
        step(1);
        bus.init_regs = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst               = 1'b1;
        bus.init_regs     = 1'b0;
        bus.count_enabled = 1'b0;
        bus.count_down    = 1'b0;
        bus.load          = 1'b0;
        bus.load_value    = '0;
        bus.lap_push      = 1'b0;
        bus.lap_pop       = 1'b0;
        bus.show_lap      = 1'b0;
        step(2);
        check("rst_reading", bus.time_reading, 32'h0);
        check("rst_count", bus.lap_count, 32'd0);
        check("rst_empty", bus.lap_empty, 32'd1);
        check("rst_full", bus.lap_full, 32'd0);
        check("rst_expired", bus.expired, 32'd0);
        check("rst_overflow", bus.overflow, 32'd0);
        rst = 1'b0;
        step(1);

        // 1000 clocks = 100 ticks
        bus.count_enabled = 1'b1;
        step(1000);
        bus.count_enabled = 1'b0;
        check("up_1000clk", bus.time_reading, 32'h0100);
        check("up_no_ovf", bus.overflow, 32'd0);
        step(5);
        check("hold_disabled", bus.time_reading, 32'h0100);

`ifdef LAP_TIMER_COUNTDOWN_EN
        bus.load_value = 16'h9995;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        check("load_9995", bus.time_reading, 32'h9995);
        bus.count_enabled = 1'b1;
        step(49);
        check("up_9999", bus.time_reading, 32'h9999);
        check("ovf_before_wrap", bus.overflow, 32'd0);
        step(1);
        bus.count_enabled = 1'b0;
        check("wrap_0000", bus.time_reading, 32'h0000);
        check("ovf_set", bus.overflow, 32'd1);
        step(3);
        check("ovf_sticky", bus.overflow, 32'd1);
        pulse_init();
        check("init_reading", bus.time_reading, 32'h0);
        check("init_ovf", bus.overflow, 32'd0);

        bus.count_down = 1'b1;
        bus.load_value = 16'h0003;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        bus.count_enabled = 1'b1;
        step(29);
        check("down_0001", bus.time_reading, 32'h0001);
        check("no_early_exp", bus.expired, 32'd0);
        step(1);
        check("down_0000", bus.time_reading, 32'h0000);
        check("expired_pulse", bus.expired, 32'd1);
        step(1);
        check("expired_one_cyc", bus.expired, 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.expired) pulses++;
        end
        check("no_repeat_exp", pulses, 32'd0);
        check("hold_zero", bus.time_reading, 32'h0000);
        bus.count_enabled = 1'b0;
        bus.load_value = 16'h00AF;
        bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        check("load_clamp", bus.time_reading, 32'h0099);
        bus.count_enabled = 1'b1;
        step(10);
        bus.count_enabled = 1'b0;
        check("down_0098", bus.time_reading, 32'h0098);
        bus.count_down = 1'b0;
`else
        bus.load_value = 16'h1234;
        bus.load = 1'b1;
        bus.count_down = 1'b1;
        step(1);
        bus.load = 1'b0;
        check("load_ignored", bus.time_reading, 32'h0100);
        bus.count_enabled = 1'b1;
        step(10);
        bus.count_enabled = 1'b0;
        check("down_ignored", bus.time_reading, 32'h0101);
        check("expired_tied", bus.expired, 32'd0);
        bus.count_down = 1'b0;
`endif
        pulse_init();
        check("init_clear", bus.time_reading, 32'h0);

        // Laps at readings 0001..0005; the fifth is dropped.
        for (int k = 1; k <= 5; k++) begin
            bus.count_enabled = 1'b1;
            step(10);
            bus.count_enabled = 1'b0;
            push_lap();
            check($sformatf("lap_count_%0d", k), bus.lap_count, (k < 4) ? k : 4);
        end
        check("lap_full", bus.lap_full, 32'd1);
        check("live_0005", bus.time_reading, 32'h0005);
        bus.show_lap = 1'b1;
        #1;
        check("show_head", bus.time_reading, 32'h0001);
        bus.show_lap = 1'b0;
        #1;
        check("show_off", bus.time_reading, 32'h0005);
        bus.show_lap = 1'b1;
        #1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("head_%0d", k), bus.time_reading, k);
            pop_lap();
        end
        check("empty_after", bus.lap_empty, 32'd1);
        check("empty_live", bus.time_reading, 32'h0005);
        pop_lap();
        check("pop_empty_cnt", bus.lap_count, 32'd0);
        check("pop_empty_live", bus.time_reading, 32'h0005);
        bus.show_lap = 1'b0;

        // Two entries (0006, 0007), then push+pop at 0008.
        for (int k = 0; k < 2; k++) begin
            bus.count_enabled = 1'b1;
            step(10);
            bus.count_enabled = 1'b0;
            push_lap();
        end
        bus.count_enabled = 1'b1;
        step(10);
        bus.count_enabled = 1'b0;
        bus.lap_push = 1'b1;
        bus.lap_pop  = 1'b1;
        step(1);
        bus.lap_push = 1'b0;
        bus.lap_pop  = 1'b0;
        check("pushpop_cnt", bus.lap_count, 32'd2);
        bus.show_lap = 1'b1;
        #1;
        check("pushpop_head", bus.time_reading, 32'h0007);
        pop_lap();
        check("head_0008", bus.time_reading, 32'h0008);
        pop_lap();
        check("drained", bus.lap_count, 32'd0);
        bus.lap_push = 1'b1;
        bus.lap_pop  = 1'b1;
        step(1);
        bus.lap_push = 1'b0;
        bus.lap_pop  = 1'b0;
        check("pushpop_empty", bus.lap_count, 32'd1);
        check("pushpop_e_head", bus.time_reading, 32'h0008);

        // Three entries stored, then async reset mid-tick.
        push_lap();
        push_lap();
        check("three_laps", bus.lap_count, 32'd3);
        bus.count_enabled = 1'b1;
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_reading", bus.time_reading, 32'h0);
        check("arst_count", bus.lap_count, 32'd0);
        check("arst_empty", bus.lap_empty, 32'd1);
        check("arst_full", bus.lap_full, 32'd0);
        check("arst_expired", bus.expired, 32'd0);
        check("arst_overflow", bus.overflow, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(9);
        check("post_rst_9clk", bus.time_reading, 32'h0000);
        step(1);
        check("post_rst_tick", bus.time_reading, 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised BCD stopwatch/timer: DIGITS decimal digits advanced once per prescaled tick, with optional count-down mode (preset load, expiry pulse) and a LAP_DEPTH-deep FIFO of captured lap readings. It is the next-generation time-keeping core feeding the seven-segment display path. It replaces the fixed 4-digit, single-sample counter.

## Interface
- CLK_FREQ, 100000000: input clock frequency in Hz.
- TICK_HZ, 100: count rate in Hz. CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- DIGITS, 4: number of BCD digits, 1..8. Digit 0 is least significant.
- LAP_DEPTH, 4: number of lap FIFO entries, ≥ 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_regs  in  1  synchronous clear of counter, prescaler, flags and lap FIFO.
- count_enabled  in  1  prescaler and digits advance only while high.
- count_down  in  1  1 = decrement, 0 = increment.
- load  in  1  synchronous preset of digits from load_value.
- load_value  in  4*DIGITS  BCD preset, digit i at bits [4i+3:4i].
- lap_push  in  1  capture live reading into lap FIFO.
- lap_pop  in  1  discard oldest lap entry.
- show_lap  in  1  select FIFO head instead of live reading.
- time_reading  out  4*DIGITS  displayed BCD value.
- lap_count  out  $clog2(LAP_DEPTH+1)  entries held.
- lap_empty  out  1  lap_count == 0.
- lap_full  out  1  lap_count == LAP_DEPTH.
- expired  out  1  one-cycle pulse on count-down reaching zero.
- overflow  out  1  sticky; set when up-count wraps.

## Operation
- Priority, highest first: rst > init_regs > load > tick update. Lap push/pop are evaluated independently of load/tick in the same cycle, except under rst/init_regs.
- Prescaler counts 0..CLK_FREQ/TICK_HZ−1 while count_enabled. A tick is the cycle at terminal count; the prescaler wraps to 0 on that cycle. With count_enabled low, the prescaler and digits hold.
- Up tick: BCD increment with carry chain. Digit 9 with carry-in becomes 0 and carries out. All digits 9 wraps to all 0 and sets overflow.
- Down tick: BCD decrement with borrow chain. Digit 0 with borrow becomes 9. A tick reaching all-zero pulses expired for that one cycle. While all-zero in down mode, ticks leave the digits at zero and no further expired pulse occurs.
- load: digits ← load_value, with any nibble >9 clamped to 9. Clears the prescaler, overflow and any pending expired.
- init_regs: digits 0, prescaler 0, overflow 0, expired 0, FIFO emptied.
- Lap FIFO:
  - Push stores the live digits as registered at that clock, i.e. the value before that cycle's update.
  - Push when full is dropped with no state change.
  - Pop when empty is ignored.
  - Push and pop together when non-empty: both take effect and lap_count is unchanged. When empty, only the push takes effect.
- time_reading = FIFO head when show_lap and !lap_empty; otherwise the live digits.

## Timing
- Reset values: all digits 0, time_reading 0, lap_count 0, lap_empty 1, lap_full 0, expired 0, overflow 0.
- The digit update is visible on time_reading the cycle after the tick cycle.
- expired is registered and asserts in the same cycle the zero value appears.
- The show_lap mux is combinational; time_reading follows show_lap in the same cycle.
- lap_count, lap_empty and lap_full update one cycle after push/pop.
- rst asserted mid-count or mid-FIFO-operation returns everything to reset values immediately. Counting resumes from 0 with a fresh prescaler after rst deasserts.

## Configuration
- LAP_TIMER_COUNTDOWN_EN defined:
  - count_down, load and load_value are functional.
  - expired is generated as above.
- Undefined:
  - count_down, load and load_value are ignored; the block always counts up.
  - expired is tied to 0.
  - The port list is unchanged.

## Test plan
All scenarios use CLK_FREQ=1000, TICK_HZ=100, DIGITS=4, LAP_DEPTH=4, giving 10 clocks per tick.
- Enable for 1000 clocks from reset → time_reading 16'h0100; overflow 0.
- Load 16'h9995, then up-count 5 ticks → 16'h0000 and overflow=1. Then init_regs → 0000 with overflow 0.
- (EN) Load 16'h0003 with count_down=1 → after 3 ticks reads 0000, expired high exactly one cycle. Further ticks hold 0000 with no pulse. Load 16'h00AF → reads 16'h0099.
- Push 5 laps at distinct readings → lap_full after 4, and the 5th push is dropped. Pops with show_lap=1 show the first four readings in order. A pop when empty → lap_count stays 0 and time_reading shows live.
- With 2 entries, push+pop in the same cycle → lap_count stays 2 and the head advances. With 0 entries, push+pop → lap_count 1.
- Assert rst asynchronously mid-tick with 3 laps stored → all outputs reach reset values before the next edge. The first tick after release occurs 10 clocks later.
